// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package add_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int NIB_W = 4;

  // Index counter needs at least one bit even for a single-nibble adder.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_slice.sv
// Shared 4-bit add slice: {cout, s} = x + y + cin.
module nibble_add_slice
  import add_seq_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Multi-cycle WIDTH-bit adder: one nibble per cycle through a single add slice,
// LSB first, with valid/ready handshakes on job input and result output.
module nibble_serial_add_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             zero,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  generate
    if (WIDTH < NIB_W || (WIDTH % NIB_W) != 0) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_e           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, sum_r, sum_nxt;
  logic [IDX_W-1:0] idx;
  logic             carry_r, carry_out_r, zero_r;
  logic [NIB_W-1:0] slice_s;
  logic             slice_c;
  logic             accept, last;

  nibble_add_slice u_slice (
    .x    (a_sh[NIB_W-1:0]),
    .y    (b_sh[NIB_W-1:0]),
    .cin  (carry_r),
    .s    (slice_s),
    .cout (slice_c)
  );

  assign start_ready = (state == IDLE) && !rst;
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign accept      = start_valid && start_ready;
  assign last        = (idx == LAST_IDX);
  assign sum         = sum_r;
  assign carry_out   = carry_out_r;
  assign zero        = zero_r;

  // Zero flag must see the nibble being written this cycle, so it is taken
  // from the merged value rather than the stale register.
  always_comb begin
    sum_nxt = sum_r;
    sum_nxt[int'(idx) * NIB_W +: NIB_W] = slice_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh        <= '0;
      b_sh        <= '0;
      carry_r     <= 1'b0;
      idx         <= '0;
      sum_r       <= '0;
      carry_out_r <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_sh    <= a;
          b_sh    <= b;
          carry_r <= carry_in;
          idx     <= '0;
          sum_r   <= '0;
        end
        RUN: begin
          sum_r   <= sum_nxt;
          carry_r <= slice_c;
          a_sh    <= a_sh >> NIB_W;
          b_sh    <= b_sh >> NIB_W;
          idx     <= idx + 1'b1;
          if (last) begin
            carry_out_r <= slice_c;
            zero_r      <= (sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that adds two WIDTH-bit operands over several cycles using a single shared 4-bit add slice, one nibble per cycle, LSB nibble first, with the carry held in a register between nibbles. It accepts jobs through a valid/ready handshake and returns the result through a second valid/ready handshake. It sits between a requester (bus or register block) and the 4-bit adder datapath, and trades latency for area on wide additions.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4, otherwise elaboration fails.
NIBBLES, WIDTH/4, derived; number of RUN cycles; not user-overridable.

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
start_valid  in  1  requester presents a job
start_ready  out  1  block can accept a job
a  in  WIDTH  operand A, sampled only on start handshake
b  in  WIDTH  operand B, sampled only on start handshake
carry_in  in  1  initial carry, sampled only on start handshake
res_valid  out  1  result available
res_ready  in  1  consumer takes result
sum  out  WIDTH  registered result
carry_out  out  1  carry out of the MSB nibble
zero  out  1  high when sum == 0
busy  out  1  high in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE. Registers: state, a_sh, b_sh (shift registers, WIDTH bits), carry_r, idx (clog2(NIBBLES) bits, min 1), sum_r, zero_r.
- Reset (rst=1 at an edge): state=IDLE, idx=0, carry_r=0, a_sh=b_sh=0, sum=0, carry_out=0, zero=0, res_valid=0, busy=0. start_ready=0 while rst is high and 1 after release. Reset wins over every other event, including mid-RUN and mid-DONE; an in-flight job is discarded with no result produced.
- start_ready = (state==IDLE) && !rst. res_valid = (state==DONE). busy = (state!=IDLE).
- IDLE: on start_valid && start_ready: latch a→a_sh, b→b_sh, carry_in→carry_r, idx=0, clear sum_r; go to RUN. Otherwise hold.
- RUN, each cycle: slice computes {c,s} = a_sh[3:0] + b_sh[3:0] + carry_r (5-bit result). Write s into sum_r nibble idx. Set carry_r=c. Shift a_sh and b_sh right by 4. Increment idx. When idx==NIBBLES-1, go to DONE and load carry_out=c and zero = (all nibbles including s == 0).
- Latency: res_valid rises exactly NIBBLES cycles after the accepting edge (4 for WIDTH=16). Throughput is one job per NIBBLES+2 cycles when res_ready is tied high.
- DONE: sum, carry_out and zero stay stable while res_valid && !res_ready. On res_ready, go to IDLE the next edge. start_ready then becomes 1 one cycle after the result handshake, so jobs never overlap.
- start_valid outside IDLE is ignored, and changes on a, b or carry_in outside the handshake have no effect. res_ready outside DONE is ignored.
- sum/carry_out keep the last result in IDLE until the next accept clears sum_r. zero is updated only when entering DONE.
- Arithmetic is unsigned modulo 2^WIDTH, with the carry reported in carry_out. There is no signed-overflow output.

Decomposition:
- Package add_seq_pkg: state enum (IDLE, RUN, DONE), constant NIB_W=4, and a function computing the idx width from NIBBLES.
- One sub-module, nibble_add_slice: purely combinational, inputs 4-bit x, 4-bit y and cin; outputs {cout,s} = x+y+cin. The controller instantiates it once.

Test Plan:
- WIDTH=16; accept a=0x1234, b=0x4321, carry_in=0 → res_valid exactly 4 cycles later; sum=0x5555, carry_out=0, zero=0.
- a=0xFFFF, b=0x0001, carry_in=0 → carry ripples through all 4 nibbles; sum=0x0000, carry_out=1, zero=1. Also a=0xFFFF, b=0x0000, carry_in=1 → same result.
- Backpressure: a=0x00F0, b=0x0F10 → sum=0x1000. Hold res_ready=0 for 5 cycles: sum/carry_out/zero stay stable, start_ready=0, and a concurrent start_valid with other data is ignored. Raise res_ready → IDLE next cycle, start_ready=1.
- Reset mid-RUN: accept 0xAAAA+0x5555, then assert rst after 2 RUN cycles → next cycle state=IDLE, res_valid=0, busy=0, sum=0, carry_out=0. After release, a new job 0x0001+0x0001 → sum=0x0002.
- Back-to-back with res_ready tied 1 and start_valid held: jobs are accepted every 6 cycles (NIBBLES+2). Run a random 200-job sweep, checking {carry_out,sum} against a+b+carry_in, and zero against sum==0.
- WIDTH=4 (NIBBLES=1): a=0x9, b=0x8, carry_in=1 → res_valid 1 cycle after accept; sum=0x2, carry_out=1.
